// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and streams them one bit per clock,
// double-buffered through a holding register so consecutive words run without gaps.
module serial_word_feeder #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             shift_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   shift_reg, shift_reg_n;
    logic [WIDTH-1:0]   hold_reg, hold_reg_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               hold_full, hold_full_n;
    logic               active;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_reg_n;
            hold_reg  <= hold_reg_n;
            cnt       <= cnt_n;
            hold_full <= hold_full_n;
        end
    end

    // Next-state: accept into hold, then transfer/shift when enabled
    always_comb begin
        state_n     = state;
        shift_reg_n = shift_reg;
        hold_reg_n  = hold_reg;
        cnt_n       = cnt;
        hold_full_n = hold_full;

        // Accept only needs an empty hold, so it can never collide with a transfer
        if (word_valid && !hold_full) begin
            hold_reg_n  = word_in;
            hold_full_n = 1'b1;
        end

        if (shift_en) begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shift_reg_n = hold_reg;
                        cnt_n       = '0;
                        hold_full_n = 1'b0;
                        state_n     = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        shift_reg_n = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
                        cnt_n       = cnt + CW'(1);
                    end else if (hold_full) begin
                        shift_reg_n = hold_reg;
                        cnt_n       = '0;
                        hold_full_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output decode from registers only
    assign active     = (state == SHIFT);
    assign word_ready = ~hold_full;
    assign bit_valid  = active;
    assign bit_out    = active & (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
    assign word_done  = active & (cnt == LAST);
    assign busy       = active | hold_full;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: MSB-first and LSB-first instances share stimulus and are checked
// every cycle against a word-level model, plus literal checks on the collected serial streams.
module tb_serial_word_feeder;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] word_in = '0;
    logic       word_valid = 1'b0;
    logic       shift_en = 1'b1;
    logic [1:0] ready, bout, bval, done, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // lane 0: MSB first, lane 1: LSB first
    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(ready[0]), .shift_en(shift_en), .bit_out(bout[0]),
        .bit_valid(bval[0]), .word_done(done[0]), .busy(busy[0]));

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(ready[1]), .shift_en(shift_en), .bit_out(bout[1]),
        .bit_valid(bval[1]), .word_done(done[1]), .busy(busy[1]));

    // Word-level model: which word is in flight, which bit index, and an optional held word
    bit         m_act[2]  = '{0, 0};
    int         m_idx[2]  = '{0, 0};
    logic [3:0] m_word[2] = '{4'h0, 4'h0};
    logic [3:0] m_hold[2] = '{4'h0, 4'h0};
    bit         m_full[2] = '{0, 0};
    bit         m_acc;

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                m_act[l] = 0; m_idx[l] = 0; m_word[l] = '0; m_hold[l] = '0; m_full[l] = 0;
            end else begin
                m_acc = word_valid && !m_full[l];
                if (shift_en) begin
                    if (m_act[l] && m_idx[l] < W - 1) begin
                        m_idx[l] = m_idx[l] + 1;
                    end else if (m_full[l]) begin
                        m_word[l] = m_hold[l]; m_idx[l] = 0; m_act[l] = 1; m_full[l] = 0;
                    end else begin
                        m_act[l] = 0;
                    end
                end
                if (m_acc) begin
                    m_hold[l] = word_in; m_full[l] = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream capture: a bit counts once, on the cycle whose following edge advances it
    logic [15:0] seq[2];
    int          nb[2];
    int          ndone[2];
    int          nstart[2];
    bit          prev_v[2];
    logic [3:0]  hist;
    int          dpos;
    logic [15:0] det_mask;
    logic        e_bit;

    initial begin
        for (int l = 0; l < 2; l++) begin
            seq[l] = '0; nb[l] = 0; ndone[l] = 0; nstart[l] = 0; prev_v[l] = 0;
        end
        hist = '0; dpos = 0; det_mask = '0;
    end

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            e_bit = m_act[l] ? ((l == 0) ? m_word[l][W-1-m_idx[l]] : m_word[l][m_idx[l]]) : 1'b0;
            chk($sformatf("ready[%0d]", l), 32'(ready[l]), 32'(!m_full[l]));
            chk($sformatf("bit_valid[%0d]", l), 32'(bval[l]), 32'(m_act[l]));
            chk($sformatf("bit_out[%0d]", l), 32'(bout[l]), 32'(e_bit));
            chk($sformatf("word_done[%0d]", l), 32'(done[l]), 32'(m_act[l] && m_idx[l] == W - 1));
            chk($sformatf("busy[%0d]", l), 32'(busy[l]), 32'(m_act[l] || m_full[l]));
            if (bval[l] === 1'b1 && shift_en) begin
                seq[l] = {seq[l][14:0], bout[l]};
                nb[l]++;
                if (done[l] === 1'b1) ndone[l]++;
                if (l == 0) begin
                    hist = {hist[2:0], bout[0]};
                    if (dpos >= 3 && hist == 4'b1101 && dpos < 16) det_mask[dpos] = 1'b1;
                    dpos++;
                end
            end
            if (bval[l] === 1'b1 && !prev_v[l]) nstart[l]++;
            prev_v[l] = (bval[l] === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        for (int l = 0; l < 2; l++) begin
            seq[l] = '0; nb[l] = 0; ndone[l] = 0; nstart[l] = 0;
        end
        hist = '0; dpos = 0; det_mask = '0;
    endtask

    task automatic send(input logic [3:0] w);
        bit r;
        bit ok;
        ok = 0;
        word_in = w;
        word_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            r = ready[0];
            tick();
            if (r) ok = 1;
        end
        word_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: word %0h not accepted within 40 cycles", w);
        end
    endtask

    task automatic chk_seq(input string name, input int l, input logic [15:0] exp, input int n);
        chk({name, "_len"}, 32'(nb[l]), 32'(n));
        chk({name, "_bits"}, 32'(seq[l]), 32'(exp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b1; shift_en = 1'b1;
        run(2);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'(2'b11));
        chk("rst_valid", 32'(bval), 32'(2'b00));
        chk("rst_busy",  32'(busy), 32'(2'b00));
        chk("rst_done",  32'(done), 32'(2'b00));

        // Single word 1101, latency and ordering
        clear();
        send(4'b1101);
        chk("lat_accept_valid", 32'(bval[0]), 32'(1'b0));
        chk("lat_accept_busy",  32'(busy[0]), 32'(1'b1));
        tick();
        chk("lat_first_valid", 32'(bval[0]), 32'(1'b1));
        chk("lat_first_bit",   32'(bout[0]), 32'(1'b1));
        run(6);
        chk_seq("single_msb", 0, 16'b1101, 4);
        chk_seq("single_lsb", 1, 16'b1011, 4);
        chk("single_done_cnt", 32'(ndone[0]), 32'(1));
        chk("single_idle", 32'({bval, busy}), 32'(4'b0000));

        // Back-to-back words, gapless
        clear();
        send(4'b1101);
        send(4'b1011);
        send(4'b0110);
        run(14);
        chk_seq("b2b_msb", 0, 16'b1101_1011_0110, 12);
        chk_seq("b2b_lsb", 1, 16'b1011_1101_0110, 12);
        chk("b2b_runs", 32'(nstart[0]), 32'(1));
        chk("b2b_done_cnt", 32'(ndone[0]), 32'(3));

        // Stall after the 2nd bit, word accepted during the stall
        clear();
        send(4'b1101);
        tick();
        tick();
        shift_en = 1'b0;
        send(4'b0110);
        chk("stall_bit_msb", 32'(bout[0]), 32'(1'b1));
        chk("stall_bit_lsb", 32'(bout[1]), 32'(1'b0));
        chk("stall_held", 32'(ready[0]), 32'(1'b0));
        tick();
        chk("stall_bit_msb2", 32'(bout[0]), 32'(1'b1));
        tick();
        shift_en = 1'b1;
        run(12);
        chk_seq("stall_msb", 0, 16'b1101_0110, 8);
        chk_seq("stall_lsb", 1, 16'b1011_0110, 8);

        // Reset on the 3rd bit with a word held
        clear();
        send(4'b1101);
        send(4'b1011);
        tick();
        chk("pre_rst_full", 32'(ready[0]), 32'(1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bval), 32'(2'b00));
        chk("mid_rst_busy",  32'(busy), 32'(2'b00));
        chk("mid_rst_ready", 32'(ready), 32'(2'b11));
        run(8);
        chk_seq("mid_rst_msb", 0, 16'b110, 3);
        chk_seq("mid_rst_lsb", 1, 16'b101, 3);

        // Stream 1101 1010 into a 1101 overlap detector: hits on bits 3 and 6
        clear();
        send(4'b1101);
        send(4'b1010);
        run(10);
        chk_seq("det_stream", 0, 16'b1101_1010, 8);
        chk("det_hits", 32'(det_mask), 32'(16'b0000_0000_0100_1000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
